// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: register ids, stage flags,
// memory handshake, and the stall/flush/forward controls plus counters.
interface hazard_ctrl_if #(
  parameter int CW = 16
);
  logic [4:0]    rs1D, rs2D;
  logic [4:0]    rs1E, rs2E, rdE;
  logic          loadE;
  logic          pcSrcE;
  logic [4:0]    rdM, rdW;
  logic          regWriteM, regWriteW;
  logic          memReqM, memReadyM;
  logic          clrCnt;
  logic          stallF, stallD, stallE, stallM;
  logic          flushD, flushE, flushW;
  logic [1:0]    forwardAE, forwardBE;
  logic          memTimeout;
  logic [CW-1:0] stallCnt, flushCnt;

  modport master (
    output rs1D, rs2D, rs1E, rs2E, rdE, loadE, pcSrcE, rdM, rdW,
           regWriteM, regWriteW, memReqM, memReadyM, clrCnt,
    input  stallF, stallD, stallE, stallM, flushD, flushE, flushW,
           forwardAE, forwardBE, memTimeout, stallCnt, flushCnt
  );

  modport slave (
    input  rs1D, rs2D, rs1E, rs2E, rdE, loadE, pcSrcE, rdM, rdW,
           regWriteM, regWriteW, memReqM, memReadyM, clrCnt,
    output stallF, stallD, stallE, stallM, flushD, flushE, flushW,
           forwardAE, forwardBE, memTimeout, stallCnt, flushCnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the five-stage core: forwarding, load-use and
// branch bubbles, memory-wait sequencing with timeout, saturating counters.
module hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CW      = 16  // must match the CW of the connected interface
) (
  input  logic        clk,
  input  logic        reset_n,
  hazard_ctrl_if.slave bus
);
  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam logic [WW-1:0] WLAST = WW'(TIMEOUT - 1);

  typedef enum logic {S_RUN = 1'b0, S_WAIT = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic [CW-1:0] flush_cnt_q, flush_cnt_d;

  logic       lw_stall_s, mem_pend_s, abort_s, mem_stall_s;
  logic       stall_fd_s, flush_d_s, flush_e_s;
  logic [1:0] fwd_a_s, fwd_b_s;

  // M-stage result wins over W-stage since it is the younger write.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] rd_m,
                                         input logic wr_m, input logic [4:0] rd_w,
                                         input logic wr_w);
    logic [1:0] sel;
    if (wr_m && (rd_m != 5'd0) && (rd_m == src)) begin
      sel = 2'b10;
    end else if (wr_w && (rd_w != 5'd0) && (rd_w == src)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Hazard detection and stage controls.
  always_comb begin
    lw_stall_s  = bus.loadE && (bus.rdE != 5'd0) &&
                  ((bus.rdE == bus.rs1D) || (bus.rdE == bus.rs2D));
    mem_pend_s  = bus.memReqM && !bus.memReadyM;
    abort_s     = (state_q == S_WAIT) && (wcnt_q == WLAST) && mem_pend_s;
    mem_stall_s = mem_pend_s && !abort_s;
    stall_fd_s  = reset_n && (lw_stall_s || mem_stall_s);
    flush_d_s   = reset_n && bus.pcSrcE && !mem_stall_s;
    flush_e_s   = reset_n && (lw_stall_s || bus.pcSrcE) && !mem_stall_s;
    fwd_a_s     = 2'b00;
    fwd_b_s     = 2'b00;
    if (reset_n) begin
      fwd_a_s = fwd_sel(bus.rs1E, bus.rdM, bus.regWriteM, bus.rdW, bus.regWriteW);
      fwd_b_s = fwd_sel(bus.rs2E, bus.rdM, bus.regWriteM, bus.rdW, bus.regWriteW);
    end else begin
      fwd_a_s = 2'b00;
      fwd_b_s = 2'b00;
    end
  end

  assign bus.stallF     = stall_fd_s;
  assign bus.stallD     = stall_fd_s;
  assign bus.stallE     = reset_n && mem_stall_s;
  assign bus.stallM     = reset_n && mem_stall_s;
  assign bus.flushW     = reset_n && mem_stall_s;
  assign bus.flushD     = flush_d_s;
  assign bus.flushE     = flush_e_s;
  assign bus.forwardAE  = fwd_a_s;
  assign bus.forwardBE  = fwd_b_s;
  assign bus.memTimeout = reset_n && abort_s;
  assign bus.stallCnt   = stall_cnt_q;
  assign bus.flushCnt   = flush_cnt_q;

  // Memory-wait FSM next state and saturating counter updates.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      S_RUN: begin
        if (mem_pend_s) begin
          state_d = S_WAIT;
          wcnt_d  = WW'(1);
        end else begin
          state_d = S_RUN;
          wcnt_d  = '0;
        end
      end
      S_WAIT: begin
        if (!mem_pend_s || abort_s) begin
          state_d = S_RUN;
          wcnt_d  = '0;
        end else begin
          state_d = S_WAIT;
          wcnt_d  = wcnt_q + WW'(1);
        end
      end
      default: begin
        state_d = S_RUN;
        wcnt_d  = '0;
      end
    endcase

    if (bus.clrCnt) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      stall_cnt_d = (stall_fd_s && !(&stall_cnt_q)) ? stall_cnt_q + CW'(1) : stall_cnt_q;
      flush_cnt_d = (flush_d_s && !(&flush_cnt_q)) ? flush_cnt_q + CW'(1) : flush_cnt_q;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_RUN;
      wcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage RISC-V core. It drives the stall (enable) and flush (clear) controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the EX-stage forwarding selects. It also sequences multi-cycle data-memory waits with a timeout FSM. Saturating performance counters record stall and flush cycles.

## Interface
Parameters:
- TIMEOUT, 16, max consecutive memory-wait cycles before abort (≥2)
- CW, 16, width of performance counters

Ports:
- clk  in  1  pipeline clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- rs1D, rs2D  in  5 each  source registers in Decode
- rs1E, rs2E, rdE  in  5 each  sources/destination in Execute
- loadE  in  1  instruction in Execute is a load (ResultSrcE[0])
- pcSrcE  in  1  branch/jump taken, resolved in Execute
- rdM, rdW  in  5 each  destinations in Memory / Writeback
- regWriteM, regWriteW  in  1 each  register-write enables
- memReqM  in  1  data-memory access in Memory stage
- memReadyM  in  1  data memory completes access this cycle
- clrCnt  in  1  synchronous clear of both counters
- stallF, stallD, stallE, stallM  out  1 each  hold PC / IF-ID / ID-EX / EX-MEM (register en = ~stall)
- flushD, flushE, flushW  out  1 each  bubble into IF-ID / ID-EX / MEM-WB
- forwardAE, forwardBE  out  2 each  00 register file, 01 from W, 10 from M
- memTimeout  out  1  one-cycle pulse on memory-wait abort
- stallCnt, flushCnt  out  CW each  saturating counters

## Operation
- Forwarding (combinational): forwardAE = 10 if regWriteM & rdM≠0 & rdM==rs1E; else 01 if regWriteW & rdW≠0 & rdW==rs1E; else 00. forwardBE is the same using rs2E. M has priority over W.
- lwStall = loadE & rdE≠0 & (rdE==rs1D | rdE==rs2D).
- memStall = memReqM & ~memReadyM & ~abort, where abort = (state==WAIT & wcnt==TIMEOUT-1).
- stallF = stallD = lwStall | memStall.
- stallE = stallM = memStall.
- flushW = memStall.
- flushD = pcSrcE & ~memStall.
- flushE = (lwStall | pcSrcE) & ~memStall. A memory stall freezes the branch in Execute, and the branch is resolved after the stall releases.
- FSM states:
  - RUN: if memReqM & ~memReadyM, go to WAIT with wcnt←1; otherwise stay in RUN with wcnt←0.
  - WAIT: if memReadyM or ~memReqM, go to RUN with wcnt←0. Else if wcnt==TIMEOUT-1, abort: memTimeout=1 (combinational, that cycle), stall released, go to RUN with wcnt←0. Else wcnt←wcnt+1.
  - wcnt width is clog2(TIMEOUT)+1.
- After an abort, RUN re-enters WAIT on the next cycle if a new request is pending and not ready.
- stallCnt increments on every cycle with stallF=1. flushCnt increments on every cycle with flushD=1.
  - Both saturate at all-ones.
  - clrCnt has priority over increment.

## Timing
- Reset (reset_n low, asynchronous): state RUN, wcnt 0, stallCnt 0, flushCnt 0. All stall, flush and memTimeout outputs are forced to 0 and forwarding outputs to 00 while reset_n is low.
- Reset deassertion mid-WAIT restarts in RUN with no abort.
- Stall, flush and forward outputs are combinational, valid in the same cycle as the inputs, and have zero latency. Counters and the FSM update on the rising edge of clk.
- Load-use costs exactly 1 bubble: lwStall is high for one cycle, after which the load has advanced to M and forwarding covers the dependency.
- A memory wait of N cycles (memReadyM high on cycle N+1) holds F/D/E/M for N cycles, provided N < TIMEOUT.
- A stall never exceeds TIMEOUT-1 cycles per request. The abort cycle has no stall.
- Simultaneous lwStall and pcSrcE: flushE=1, flushD=1, stallF=stallD=1.
- Simultaneous memStall and anything else: only the memStall terms apply.

## Test plan
- Forwarding: rs1E=5, rdM=5, regWriteM=1, rdW=5, regWriteW=1 -> forwardAE=10. Then rdM=0 -> forwardAE=01. Then rs2E=0, rdW=0 -> forwardBE=00.
- Load-use: loadE=1, rdE=7, rs2D=7 for one cycle -> stallF=stallD=flushE=1 for exactly 1 cycle, stallCnt +1. With rdE=0 -> no stall.
- Branch: pcSrcE=1 for one cycle -> flushD=flushE=1 for 1 cycle, flushCnt +1. Same cycle as a load-use -> both flushes plus stallF=stallD=1.
- Memory wait: memReqM=1, memReadyM low 3 cycles then high -> stallF/D/E/M=flushW=1 for 3 cycles, memTimeout never asserted, FSM back in RUN.
- Timeout, with TIMEOUT=4 and memReadyM held low: stalls for 3 cycles, then memTimeout=1 with stalls 0 for one cycle, then stalls re-assert the following cycle. Assert reset_n low mid-WAIT -> all outputs 0 immediately and counters cleared.
- Saturation: CW=4, hold stall 20 cycles -> stallCnt=15 and stays. clrCnt together with a stall -> stallCnt=0 next edge.
